uci_msg_tx: RTL and testbench

Parametrised multi-source UCI output serializer. It sits between the engine-side producers (best-move formatter, info/debug reporters, `uciok`/`id` responder) and the UART transmit path. It owns one message buffer per source channel and arbitrates between pending messages. It streams each granted message byte-by-byte on a single valid/ready character port, optionally appending a newline. It replaces the fixed two-source output state machine with an N-channel, length-tagged, priority-configurable design.

---
 rtl/uci_msg_tx.sv | 180 ++++++++++++++++++
 tb/tb_uci_msg_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uci_msg_tx.sv
// uci_msg_tx: N-channel UCI output serializer. Buffers one message per channel,
// arbitrates (optional ch0 priority + round-robin) and streams bytes with optional newline.
module uci_msg_tx #(
    parameter  int unsigned NUM_CH    = 3,
    parameter  int unsigned MSG_LEN   = 64,
    parameter  int unsigned PRIO_CH0  = 1,
    parameter  int unsigned APPEND_NL = 1,
    parameter  int unsigned NUL_TERM  = 1,
    localparam int unsigned LW        = $clog2(MSG_LEN + 1),
    localparam int unsigned CW        = $clog2(NUM_CH)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_CH*MSG_LEN*8-1:0] msg_in,
    input  logic [NUM_CH*LW-1:0]        msg_len_in,
    input  logic [NUM_CH-1:0]           msg_in_valid,
    output logic [NUM_CH-1:0]           msg_in_ready,
    output logic [7:0]                  char_out,
    output logic                        char_out_valid,
    input  logic                        char_out_ready,
    output logic                        busy_out,
    output logic [CW-1:0]               active_ch_out
);
    localparam int unsigned IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_NL} state_t;

    state_t            r_state, w_state_nx;
    logic [NUM_CH-1:0] r_pending, w_clr;
    logic [7:0]        r_data [NUM_CH][MSG_LEN];
    logic [LW-1:0]     r_len  [NUM_CH];
    logic [CW-1:0]     r_ch, w_ch_nx, r_rr_ptr, w_rr_nx;
    logic [CW-1:0]     w_rr_ch, w_grant_ch;
    logic [LW-1:0]     r_idx, w_idx_nx, w_idx_p1;
    logic [IW-1:0]     w_nidx;
    logic [7:0]        r_char, w_char_nx, w_byte;
    logic              r_valid, w_valid_nx, r_busy;
    logic              w_hs, w_end, w_fin;
    logic              w_prio_hit, w_rr_hit, w_grant_any;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_len[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (msg_in_valid[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_len[i]     <= (msg_len_in[i*LW +: LW] > LW'(MSG_LEN)) ?
                                    LW'(MSG_LEN) : msg_len_in[i*LW +: LW];
                end else if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only read while its pending bit is set.
    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (msg_in_valid[i] && !r_pending[i]) begin
                for (int unsigned b = 0; b < MSG_LEN; b++)
                    r_data[i][b] <= msg_in[(i*MSG_LEN + b)*8 +: 8];
            end
        end
    end

    always_comb begin
        int unsigned   cand;
        logic [CW-1:0] w_c;
        w_rr_hit = 1'b0;
        w_rr_ch  = '0;
        cand     = 0;
        w_c      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = (32'(r_rr_ptr) + k) % NUM_CH;
            w_c  = CW'(cand);
            if (!w_rr_hit && r_pending[w_c] && !(PRIO_CH0 != 0 && cand == 0)) begin
                w_rr_hit = 1'b1;
                w_rr_ch  = w_c;
            end
        end
    end

    assign w_prio_hit  = (PRIO_CH0 != 0) && r_pending[0];
    assign w_grant_any = w_prio_hit || w_rr_hit;
    assign w_grant_ch  = w_prio_hit ? '0 : w_rr_ch;
    assign w_idx_p1    = r_idx + LW'(1);
    assign w_nidx      = (w_idx_p1 < LW'(MSG_LEN)) ? w_idx_p1[IW-1:0] : '0;
    assign w_hs        = r_valid && char_out_ready;

    // The next byte is examined before it is presented, so a NUL never appears on char_out.
    always_comb begin
        w_state_nx = r_state;
        w_ch_nx    = r_ch;
        w_idx_nx   = r_idx;
        w_char_nx  = r_char;
        w_valid_nx = r_valid;
        w_rr_nx    = r_rr_ptr;
        w_clr      = '0;
        w_byte     = 8'h00;
        w_end      = 1'b0;
        w_fin      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_ch_nx  = w_grant_ch;
                    w_idx_nx = '0;
                    w_byte   = r_data[w_grant_ch][0];
                    if (!w_prio_hit) w_rr_nx = w_grant_ch;
                    if (r_len[w_grant_ch] == '0 || (NUL_TERM != 0 && w_byte == 8'h00)) begin
                        w_end = 1'b1;
                    end else begin
                        w_state_nx = S_SEND;
                        w_char_nx  = w_byte;
                        w_valid_nx = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    w_byte = r_data[r_ch][w_nidx];
                    if (w_idx_p1 >= r_len[r_ch] || (NUL_TERM != 0 && w_byte == 8'h00)) begin
                        w_end = 1'b1;
                    end else begin
                        w_idx_nx  = w_idx_p1;
                        w_char_nx = w_byte;
                    end
                end
            end
            S_NL: begin
                if (w_hs) w_fin = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_end) begin
            if (APPEND_NL != 0) begin
                w_state_nx = S_NL;
                w_char_nx  = 8'h0A;
                w_valid_nx = 1'b1;
            end else begin
                w_fin = 1'b1;
            end
        end
        if (w_fin) begin
            w_clr[w_ch_nx] = 1'b1;
            w_state_nx     = S_IDLE;
            w_valid_nx     = 1'b0;
            w_char_nx      = 8'h00;
            w_ch_nx        = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_idx    <= '0;
            r_char   <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_rr_ptr <= CW'(NUM_CH - 1);
        end else begin
            r_state  <= w_state_nx;
            r_ch     <= w_ch_nx;
            r_idx    <= w_idx_nx;
            r_char   <= w_char_nx;
            r_valid  <= w_valid_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_rr_ptr <= w_rr_nx;
        end
    end

    assign msg_in_ready   = ~r_pending;
    assign char_out       = r_char;
    assign char_out_valid = r_valid;
    assign busy_out       = r_busy;
    assign active_ch_out  = r_ch;

endmodule

// File: tb/tb_uci_msg_tx.sv
// tb_uci_msg_tx: directed vector table plus hand-written multi-cycle sequences
// for uci_msg_tx at default parameters (3 channels, 64-byte messages).
module tb_uci_msg_tx;
    localparam int NCH = 3;
    localparam int ML  = 64;
    localparam int LWT = 7;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NCH*ML*8-1:0]   msg_in = '0;
    logic [NCH*LWT-1:0]    msg_len_in = '0;
    logic [NCH-1:0]        msg_in_valid = '0;
    logic [NCH-1:0]        msg_in_ready;
    logic [7:0]            char_out;
    logic                  char_out_valid;
    logic                  char_out_ready = 1'b1;
    logic                  busy_out;
    logic [1:0]            active_ch_out;

    uci_msg_tx dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .msg_in         (msg_in),
        .msg_len_in     (msg_len_in),
        .msg_in_valid   (msg_in_valid),
        .msg_in_ready   (msg_in_ready),
        .char_out       (char_out),
        .char_out_valid (char_out_valid),
        .char_out_ready (char_out_ready),
        .busy_out       (busy_out),
        .active_ch_out  (active_ch_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    int         rx_ch_q[$];
    logic [7:0] exp_q[$];
    int         ech_q[$];
    bit         stall_prev = 1'b0;
    logic [7:0] stall_char = 8'h00;
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    typedef struct {
        int           ch;
        int           len;
        logic [511:0] data;
        logic [511:0] exp;
        int           exp_n;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // '~' stands for a NUL byte, which a string cannot hold.
    function automatic logic [511:0] s2b(input string s);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = (s[i] == 8'h7E) ? 8'h00 : s[i];
        return r;
    endfunction

    task automatic set_vec(input int k, input int ch, input int len, input string d,
                           input string e);
        tbl[k].ch    = ch;
        tbl[k].len   = len;
        tbl[k].data  = s2b(d);
        tbl[k].exp   = s2b(e);
        tbl[k].exp_n = e.len();
    endtask

    task automatic clear_q();
        rx_q.delete();
        rx_ch_q.delete();
        exp_q.delete();
        ech_q.delete();
    endtask

    task automatic expect_str(input string s, input int ch);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
            ech_q.push_back(ch);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && char_out_valid && char_out_ready) begin
            rx_q.push_back(char_out);
            rx_ch_q.push_back(int'(active_ch_out));
        end
        if (rst_n && stall_prev) begin
            n_cmp++;
            if (!char_out_valid || char_out !== stall_char) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%0b char=%0h expected valid=1 char=%0h",
                         char_out_valid, char_out, stall_char);
            end
        end
        stall_prev = rst_n && char_out_valid && !char_out_ready;
        stall_char = char_out;
    end

    task automatic send_msg(input int ch, input int len, input logic [511:0] data);
        int guard;
        guard = 0;
        msg_in[ch*512 +: 512]    = data;
        msg_len_in[ch*LWT +: LWT] = 7'(len);
        msg_in_valid[ch]          = 1'b1;
        while (!msg_in_ready[ch] && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (guard >= 300) begin
            n_err++;
            $display("FAIL accept_timeout ch%0d: ready stayed %0b expected 1", ch, msg_in_ready[ch]);
        end
        @(posedge clk); #1;
        msg_in_valid[ch]          = 1'b0;
        msg_in[ch*512 +: 512]     = {16{$urandom}};
        msg_len_in[ch*LWT +: LWT] = 7'($urandom);
    endtask

    task automatic wait_done(input int n, input bit rnd);
        int cyc;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd) char_out_ready = pat[$urandom_range(0, 3)];
            if (rx_q.size() >= n && !busy_out && !char_out_valid) break;
        end
        char_out_ready = 1'b1;
        n_cmp++;
        if (cyc >= 400) begin
            n_err++;
            $display("FAIL done_timeout: got %0d chars expected %0d", rx_q.size(), n);
        end
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_char%0d", name, i), 64'(rx_q[i]), 64'(exp_q[i]));
            chk($sformatf("%s_ch%0d", name, i), 64'(rx_ch_q[i]), 64'(ech_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc1, acc2, cyc;
        logic [511:0] big;

        set_vec(0, 1, 13, "bestmove e2e4", "bestmove e2e4\n");
        set_vec(1, 0, 10, "uciok~xyz.",    "uciok\n");
        set_vec(2, 2, 0,  "junk",          "\n");
        set_vec(3, 1, 5,  "id name eng",   "id na\n");
        set_vec(4, 2, 1,  "~abc",          "\n");
        set_vec(5, 0, 8,  "readyok!",      "readyok!\n");

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(msg_in_ready), 64'(3'b111));
        chk("rst_valid", 64'(char_out_valid), 64'd0);
        chk("rst_char", 64'(char_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_active", 64'(active_ch_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            clear_q();
            for (int j = 0; j < tbl[k].exp_n; j++) begin
                exp_q.push_back(tbl[k].exp[j*8 +: 8]);
                ech_q.push_back(tbl[k].ch);
            end
            send_msg(tbl[k].ch, tbl[k].len, tbl[k].data);
            wait_done(tbl[k].exp_n, 1'b0);
            check_rx($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_ready", k), 64'(msg_in_ready), 64'(3'b111));
        end

        // First valid one cycle after accept; ready returns after the newline handshake.
        clear_q();
        send_msg(1, 2, s2b("go"));
        @(negedge clk);
        chk("lat_pre_valid", 64'(char_out_valid), 64'd0);
        chk("lat_pre_ready1", 64'(msg_in_ready[1]), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(char_out_valid), 64'd1);
        chk("lat_char0", 64'(char_out), 64'h67);
        chk("lat_active", 64'(active_ch_out), 64'd1);
        chk("lat_busy", 64'(busy_out), 64'd1);
        @(negedge clk);
        chk("lat_char1", 64'(char_out), 64'h6F);
        @(negedge clk);
        chk("lat_nl", 64'(char_out), 64'h0A);
        chk("lat_nl_ready1", 64'(msg_in_ready[1]), 64'd0);
        @(negedge clk);
        chk("lat_end_valid", 64'(char_out_valid), 64'd0);
        chk("lat_end_ready1", 64'(msg_in_ready[1]), 64'd1);
        chk("lat_end_busy", 64'(busy_out), 64'd0);
        @(posedge clk); #1;

        clear_q();
        send_msg(1, 8, s2b("abcdefgh"));
        send_msg(2, 3, s2b("XYZ"));
        send_msg(0, 1, s2b("P"));
        expect_str("abcdefgh\n", 1);
        expect_str("P\n", 0);
        expect_str("XYZ\n", 2);
        wait_done(15, 1'b0);
        check_rx("prio");

        clear_q();
        msg_in[1*512 +: 512] = s2b("r1");
        msg_len_in[1*LWT +: LWT] = 7'd2;
        msg_in[2*512 +: 512] = s2b("r2");
        msg_len_in[2*LWT +: LWT] = 7'd2;
        msg_in_valid[1] = 1'b1;
        msg_in_valid[2] = 1'b1;
        acc1 = 0;
        acc2 = 0;
        cyc = 0;
        while ((acc1 < 3 || acc2 < 3) && cyc < 400) begin
            @(negedge clk);
            if (msg_in_valid[1] && msg_in_ready[1]) acc1++;
            if (msg_in_valid[2] && msg_in_ready[2]) acc2++;
            @(posedge clk); #1;
            if (acc1 >= 3) msg_in_valid[1] = 1'b0;
            if (acc2 >= 3) msg_in_valid[2] = 1'b0;
            cyc++;
        end
        msg_in_valid = '0;
        for (int r = 0; r < 3; r++) begin
            expect_str("r1\n", 1);
            expect_str("r2\n", 2);
        end
        wait_done(18, 1'b0);
        check_rx("rr");

        clear_q();
        send_msg(2, 12, s2b("info depth 5"));
        expect_str("info depth 5\n", 2);
        wait_done(13, 1'b1);
        check_rx("bp");

        clear_q();
        big = '0;
        for (int b = 0; b < ML; b++) begin
            big[b*8 +: 8] = 8'(8'h41 + (b % 26));
            exp_q.push_back(8'(8'h41 + (b % 26)));
            ech_q.push_back(0);
        end
        expect_str("\n", 0);
        send_msg(0, 100, big);
        wait_done(65, 1'b0);
        check_rx("clamp");

        clear_q();
        send_msg(1, 7, s2b("abcdefg"));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(char_out_valid && char_out == 8'h64) && cyc < 50);
        chk("rst_mid_reached", 64'(char_out), 64'h64);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(char_out_valid), 64'd0);
        chk("rst_mid_ready", 64'(msg_in_ready), 64'(3'b111));
        chk("rst_mid_busy", 64'(busy_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
        send_msg(2, 2, s2b("xy"));
        expect_str("xy\n", 2);
        wait_done(3, 1'b0);
        check_rx("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
